// File: rtl/rom_reader.sv
// rom_reader: walks a wrapping ROM address range and streams one word per cycle with last flag, checksum and done pulse.
// Latency: first word valid two cycles after start; a single output register holds the word while out_ready is low.
module rom_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        checksum,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic              slot_free;

  // The output register can take a new word when empty or draining this cycle.
  assign slot_free = !out_valid || out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rom_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= start_addr;
            remaining <= len;
            checksum  <= '0;
            state     <= (len != '0) ? READ : DONE;
          end
        end
        READ: begin
          if (slot_free) begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
            out_last  <= (remaining == LEN_W'(1));
            checksum  <= checksum + 8'(rom_data);
            addr_q    <= addr_q + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a queue-based reference model and a per-cycle compare process.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [3:0] len;
  logic       busy;
  logic [7:0] rom_addr;
  logic [3:0] rom_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic       out_last;
  logic [7:0] checksum;
  logic       done;

  rom_reader #(.ADDR_W(8), .DATA_W(4), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .checksum(checksum), .done(done)
  );

  always #5 clk = ~clk;

  // Bench ROM: word = {addr[2:0], 0}
  assign rom_data = {rom_addr[2:0], 1'b0};

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int got_q[$];
  int lit[$];
  int exp_sum = 0;
  int done_seen = 0;
  int ready_mode = 0;
  int pat = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Mode 1 gives the repeating out_ready pattern 1,0,0.
  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 0) || (pat % 3 == 0);
    pat++;
  end

  logic       prev_stall = 1'b0;
  logic [3:0] prev_data;
  logic [7:0] prev_addr;
  logic [7:0] prev_sum;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_data));
        check("stall_addr", int'(rom_addr), int'(prev_addr));
        check("stall_sum", int'(checksum), int'(prev_sum));
      end
      if (!out_valid) check("last_without_valid", int'(out_last), 0);
      if (out_valid) check("valid_has_pending_word", int'(exp_q.size() != 0), 1);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("word", int'(out_data), exp_q[0]);
        check("last", int'(out_last), int'(exp_q.size() == 1));
        got_q.push_back(int'(out_data));
        void'(exp_q.pop_front());
      end
      if (done) begin
        done_seen++;
        check("done_drained", exp_q.size(), 0);
        check("done_checksum", int'(checksum), exp_sum);
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
    prev_addr  = rom_addr;
    prev_sum   = checksum;
  end

  task automatic run_burst(input int sa, input int ln, input int mode, input int inj, input int rst_at);
    int cyc;
    int d0;
    int w;
    bit got_done;
    ready_mode = mode;
    exp_q.delete();
    got_q.delete();
    exp_sum = 0;
    for (int i = 0; i < ln; i++) begin
      w = (((sa + i) % 256) % 8) * 2;
      exp_q.push_back(w);
      exp_sum = (exp_sum + w) % 256;
    end
    d0 = done_seen;
    @(posedge clk); #1;
    check("idle_before_start", int'(busy), 0);
    start = 1'b1;
    start_addr = 8'(sa);
    len = 4'(ln);
    cyc = 0;
    got_done = 1'b0;
    while (cyc < 200 && !got_done) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == inj);
      if (cyc == inj) begin
        start_addr = 8'd4;
        len = 4'd3;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_sum = 0;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_addr", int'(rom_addr), 0);
        check("rst_sum", int'(checksum), 0);
        check("rst_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done_pulse", done_seen, d0);
        check("rst_stays_idle", int'(busy), 0);
        return;
      end
      if (cyc == 1) begin
        check("busy_c1", int'(busy), 1);
        check("valid_c1", int'(out_valid), 0);
        if (ln == 0) check("zero_len_done_c1", int'(done), 1);
      end
      if (mode == 0 && cyc >= 1 && cyc <= ln) check("rom_addr", int'(rom_addr), (sa + cyc - 1) % 256);
      if (mode == 0 && ln > 0 && cyc == 2) check("first_valid_c2", int'(out_valid), 1);
      if (done) got_done = 1'b1;
    end
    check("done_seen_in_budget", int'(got_done), 1);
    if (mode == 0) check("done_cycle", cyc, (ln == 0) ? 1 : ln + 2);
    @(negedge clk); #1;
    check("one_done_pulse", done_seen, d0 + 1);
  endtask

  task automatic check_got(input string nm, input int sum);
    check({nm, "_count"}, got_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_q.size(); i++) check({nm, "_word"}, got_q[i], lit[i]);
    check({nm, "_checksum"}, int'(checksum), sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(rom_addr), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_last", int'(out_last), 0);
    check("reset_data", int'(out_data), 0);
    check("reset_sum", int'(checksum), 0);
    rst = 1'b0;

    run_burst(0, 8, 0, -1, -1);
    lit = '{0, 2, 4, 6, 8, 10, 12, 14};
    check_got("sweep", 56);

    run_burst(0, 8, 1, -1, -1);
    check_got("backpressure", 56);

    run_burst(255, 3, 0, -1, -1);
    lit = '{14, 0, 2};
    check_got("wrap", 16);

    run_burst(0, 0, 0, -1, -1);
    lit.delete();
    check_got("zero_len", 0);

    run_burst(0, 5, 0, 3, -1);
    lit = '{0, 2, 4, 6, 8};
    check_got("start_while_busy", 20);

    // Starts immediately in the cycle after the previous burst returns to IDLE.
    run_burst(4, 2, 0, -1, -1);
    lit = '{8, 10};
    check_got("back_to_back", 18);

    run_burst(0, 8, 0, -1, 4);

    run_burst(0, 8, 0, -1, -1);
    lit = '{0, 2, 4, 6, 8, 10, 12, 14};
    check_got("after_reset", 56);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
